// File: rtl/game_pkg.sv
// Shared types and constants for the snake game-flow controller.
package game_pkg;

  typedef enum logic [2:0] {
    ST_HALTED     = 3'd0,
    ST_MENU       = 3'd1,
    ST_MAP_SELECT = 3'd2,
    ST_PLAY       = 3'd3,
    ST_PAUSED     = 3'd4,
    ST_ROUND_END  = 3'd5,
    ST_MATCH_END  = 3'd6
  } game_state_t;

  localparam logic [2:0] SCR_HALTED     = 3'd0;
  localparam logic [2:0] SCR_MENU       = 3'd1;
  localparam logic [2:0] SCR_MAP_SELECT = 3'd2;
  localparam logic [2:0] SCR_PLAY       = 3'd3;
  localparam logic [2:0] SCR_PAUSED     = 3'd4;
  localparam logic [2:0] SCR_ROUND_END  = 3'd5;
  localparam logic [2:0] SCR_MATCH_END  = 3'd6;

  localparam logic [7:0] DEF_START_KEY = 8'd88;
  localparam logic [7:0] DEF_PAUSE_KEY = 8'd41;
  localparam logic [7:0] DEF_NEXT_KEY  = 8'd79;

  localparam int unsigned KEY_IDX_START = 0;
  localparam int unsigned KEY_IDX_PAUSE = 1;
  localparam int unsigned KEY_IDX_NEXT  = 2;
  localparam int unsigned NUM_CTRL_KEYS = 3;

  // Index width with a floor of one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [2:0] screen_of(input game_state_t st);
    logic [2:0] code;
    code = SCR_HALTED;
    case (st)
      ST_HALTED:     code = SCR_HALTED;
      ST_MENU:       code = SCR_MENU;
      ST_MAP_SELECT: code = SCR_MAP_SELECT;
      ST_PLAY:       code = SCR_PLAY;
      ST_PAUSED:     code = SCR_PAUSED;
      ST_ROUND_END:  code = SCR_ROUND_END;
      ST_MATCH_END:  code = SCR_MATCH_END;
      default:       code = SCR_HALTED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Game-flow bus: keyboard/game-logic inputs and screen/strobe outputs.
// master = controller, slave = keyboard driver / game logic / colour mapper.
// timer_expired exists only when ROUND_TIMER_EN is defined.
interface game_flow_ctrl_if
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned NUM_MAPS      = 2,
  parameter int unsigned ROUNDS_TO_WIN = 3,
  parameter int unsigned KEY_SLOTS     = 2
);
  localparam int unsigned PW = idx_width(NUM_PLAYERS);
  localparam int unsigned MW = idx_width(NUM_MAPS);
  localparam int unsigned SW = $clog2(ROUNDS_TO_WIN + 1);

  logic [8*KEY_SLOTS-1:0]      keycode;
  logic                        round_over;
  logic [PW-1:0]               round_winner;
  logic                        round_tie;
  logic [2:0]                  screen;
  logic [MW-1:0]               map_sel;
  logic                        play_en;
  logic                        pause_en;
  logic                        new_round;
  logic [NUM_PLAYERS*SW-1:0]   scores;
  logic [PW-1:0]               match_winner;
`ifdef ROUND_TIMER_EN
  logic                        timer_expired;
`endif

  modport master (
    input  keycode, round_over, round_winner, round_tie,
    output screen, map_sel, play_en, pause_en, new_round, scores, match_winner
`ifdef ROUND_TIMER_EN
    , output timer_expired
`endif
  );

  modport slave (
    output keycode, round_over, round_winner, round_tie,
    input  screen, map_sel, play_en, pause_en, new_round, scores, match_winner
`ifdef ROUND_TIMER_EN
    , input timer_expired
`endif
  );

endinterface

// File: rtl/key_edge_detect.sv
// Matches every keycode slot against a key list and flags rising edges
// (key newly present this cycle). Ports: clk, rst_n, keycode, key_list, press.
module key_edge_detect #(
  parameter int unsigned KEY_SLOTS = 2,
  parameter int unsigned NUM_KEYS  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*KEY_SLOTS-1:0] keycode,
  input  logic [8*NUM_KEYS-1:0]  key_list,
  output logic [NUM_KEYS-1:0]    press
);

  logic [NUM_KEYS-1:0] hit_d;
  logic [NUM_KEYS-1:0] hit_q;

  always_comb begin
    hit_d = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      for (int unsigned s = 0; s < KEY_SLOTS; s++) begin
        if (keycode[8*s +: 8] == key_list[8*k +: 8]) begin
          hit_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign press = hit_d & ~hit_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: menu/map-select/play/pause/round-end/match-end
// sequencing, best-of-N scoring, screen select and snake enable strobes.
// Ports: Clk, Reset_n (async, active low), bus (game_flow_ctrl_if.master).
// Optional round time limit: define ROUND_TIMER_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned NUM_MAPS      = 2,
  parameter int unsigned ROUNDS_TO_WIN = 3,
  parameter int unsigned KEY_SLOTS     = 2,
  parameter logic [7:0]  START_KEY     = DEF_START_KEY,
  parameter logic [7:0]  PAUSE_KEY     = DEF_PAUSE_KEY,
  parameter logic [7:0]  NEXT_KEY      = DEF_NEXT_KEY
`ifdef ROUND_TIMER_EN
  , parameter logic [31:0] ROUND_CYCLES = 32'd150_000_000
`endif
) (
  input  logic              Clk,
  input  logic              Reset_n,
  game_flow_ctrl_if.master  bus
);

  localparam int unsigned PW = idx_width(NUM_PLAYERS);
  localparam int unsigned MW = idx_width(NUM_MAPS);
  localparam int unsigned SW = $clog2(ROUNDS_TO_WIN + 1);

  game_state_t state_q, state_d;
  logic [MW-1:0]                   map_sel_q, map_sel_d;
  logic [NUM_PLAYERS-1:0][SW-1:0]  scores_q, scores_d;
  logic [PW-1:0]                   match_winner_q, match_winner_d;
  logic [2:0]                      screen_q, screen_d;
  logic                            play_en_q, play_en_d;
  logic                            pause_en_q, pause_en_d;
  logic                            new_round_q, new_round_d;

  logic [NUM_CTRL_KEYS-1:0] press;
  logic                     win_valid;
  logic                     timer_hit;

  key_edge_detect #(
    .KEY_SLOTS (KEY_SLOTS),
    .NUM_KEYS  (NUM_CTRL_KEYS)
  ) u_keys (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .keycode  (bus.keycode),
    .key_list ({NEXT_KEY, PAUSE_KEY, START_KEY}),
    .press    (press)
  );

  assign win_valid = !bus.round_tie && (32'(bus.round_winner) < NUM_PLAYERS);

  always_comb begin
    state_d        = state_q;
    map_sel_d      = map_sel_q;
    scores_d       = scores_q;
    match_winner_d = match_winner_q;
    new_round_d    = 1'b0;

    case (state_q)
      ST_HALTED: state_d = ST_MENU;

      ST_MENU: begin
        if (press[KEY_IDX_START]) begin
          state_d        = ST_MAP_SELECT;
          scores_d       = '0;
          match_winner_d = '0;
        end
      end

      ST_MAP_SELECT: begin
        if (press[KEY_IDX_START]) begin
          state_d     = ST_PLAY;
          new_round_d = 1'b1;
        end else if (press[KEY_IDX_NEXT]) begin
          map_sel_d = (map_sel_q == MW'(NUM_MAPS - 1)) ? '0 : map_sel_q + 1'b1;
        end
      end

      ST_PLAY: begin
        if (bus.round_over) begin
          state_d = ST_ROUND_END;
          if (win_valid) begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
              if ((bus.round_winner == PW'(p)) && (scores_q[p] < SW'(ROUNDS_TO_WIN))) begin
                scores_d[p] = scores_q[p] + 1'b1;
                if (scores_d[p] == SW'(ROUNDS_TO_WIN)) begin
                  match_winner_d = bus.round_winner;
                  state_d        = ST_MATCH_END;
                end
              end
            end
          end
        end else if (timer_hit) begin
          state_d = ST_ROUND_END;
        end else if (press[KEY_IDX_PAUSE]) begin
          state_d = ST_PAUSED;
        end
      end

      ST_PAUSED: begin
        if (press[KEY_IDX_PAUSE]) begin
          state_d = ST_PLAY;
        end
      end

      ST_ROUND_END: begin
        if (press[KEY_IDX_START]) begin
          state_d     = ST_PLAY;
          new_round_d = 1'b1;
        end
      end

      ST_MATCH_END: begin
        if (press[KEY_IDX_START]) begin
          state_d = ST_MENU;
        end
      end

      default: state_d = ST_HALTED;
    endcase

    // Moore outputs register the current state, so they trail it by a cycle.
    screen_d   = screen_of(state_q);
    play_en_d  = (state_q == ST_PLAY);
    pause_en_d = (state_q == ST_PAUSED);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= ST_HALTED;
      map_sel_q      <= '0;
      scores_q       <= '0;
      match_winner_q <= '0;
      screen_q       <= SCR_HALTED;
      play_en_q      <= 1'b0;
      pause_en_q     <= 1'b0;
      new_round_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      map_sel_q      <= map_sel_d;
      scores_q       <= scores_d;
      match_winner_q <= match_winner_d;
      screen_q       <= screen_d;
      play_en_q      <= play_en_d;
      pause_en_q     <= pause_en_d;
      new_round_q    <= new_round_d;
    end
  end

`ifdef ROUND_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic        timer_expired_q, timer_expired_d;

  assign timer_hit = (state_q == ST_PLAY) && (timer_q == '0);

  always_comb begin
    timer_d         = timer_q;
    timer_expired_d = timer_hit && !bus.round_over;
    if (new_round_d) begin
      timer_d = ROUND_CYCLES - 32'd1;
    end else if ((state_q == ST_PLAY) && (timer_q != '0)) begin
      timer_d = timer_q - 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      timer_q         <= '0;
      timer_expired_q <= 1'b0;
    end else begin
      timer_q         <= timer_d;
      timer_expired_q <= timer_expired_d;
    end
  end

  assign bus.timer_expired = timer_expired_q;
`else
  assign timer_hit = 1'b0;
`endif

  assign bus.screen       = screen_q;
  assign bus.map_sel      = map_sel_q;
  assign bus.play_en      = play_en_q;
  assign bus.pause_en     = pause_en_q;
  assign bus.new_round    = new_round_q;
  assign bus.scores       = scores_q;
  assign bus.match_winner = match_winner_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

  localparam int unsigned NP  = 3;
  localparam int unsigned NM  = 3;
  localparam int unsigned RTW = 2;
  localparam int unsigned KS  = 2;

  logic Clk;
  logic Reset_n;
  int   checks;
  int   failures;

  game_flow_ctrl_if #(
    .NUM_PLAYERS   (NP),
    .NUM_MAPS      (NM),
    .ROUNDS_TO_WIN (RTW),
    .KEY_SLOTS     (KS)
  ) bus ();

  game_flow_ctrl #(
    .NUM_PLAYERS   (NP),
    .NUM_MAPS      (NM),
    .ROUNDS_TO_WIN (RTW),
    .KEY_SLOTS     (KS),
    .START_KEY     (8'd88),
    .PAUSE_KEY     (8'd41),
    .NEXT_KEY      (8'd79)
`ifdef ROUND_TIMER_EN
    , .ROUND_CYCLES (32'd100)
`endif
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Key down for one edge, then up for one edge.
  task automatic press_key(input logic [7:0] k, input int unsigned slot);
    logic [15:0] kc;
    kc = '0;
    kc[8*slot +: 8] = k;
    bus.keycode = kc;
    tick();
    bus.keycode = '0;
    tick();
  endtask

  task automatic round_end(input logic [1:0] winner, input logic tie);
    bus.round_over   = 1'b1;
    bus.round_winner = winner;
    bus.round_tie    = tie;
    tick();
    bus.round_over   = 1'b0;
    bus.round_tie    = 1'b0;
    bus.round_winner = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.keycode      = {8'd0, 8'd88};
    bus.round_over   = 1'b0;
    bus.round_winner = '0;
    bus.round_tie    = 1'b0;
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("rst_screen",   32'(bus.screen), 32'd0);
    check("rst_map_sel",  32'(bus.map_sel), 32'd0);
    check("rst_scores",   32'(bus.scores), 32'd0);
    check("rst_winner",   32'(bus.match_winner), 32'd0);
    check("rst_strobes",  32'({bus.play_en, bus.pause_en, bus.new_round}), 32'd0);

    // Release reset with START held: HALTED one cycle, then MENU, no advance.
    Reset_n = 1'b1;
    tick();
    check("halted_cycle", 32'(bus.screen), 32'd0);
    tick();
    check("menu_entry", 32'(bus.screen), 32'd1);
    tick(); tick(); tick();
    check("held_key_no_adv", 32'(bus.screen), 32'd1);
    bus.keycode = '0;
    tick();

    // MENU -> MAP_SELECT, map cycling with NUM_MAPS=3.
    press_key(8'd88, 0);
    check("map_select", 32'(bus.screen), 32'd2);
    press_key(8'd79, 0);
    check("map_sel_1", 32'(bus.map_sel), 32'd1);
    press_key(8'd79, 1);
    check("map_sel_2_slot1", 32'(bus.map_sel), 32'd2);
    press_key(8'd79, 0);
    check("map_sel_wrap", 32'(bus.map_sel), 32'd0);
    press_key(8'd79, 0);
    check("map_sel_1_again", 32'(bus.map_sel), 32'd1);

    // START and NEXT together: START wins, map unchanged, new_round one cycle.
    bus.keycode = {8'd79, 8'd88};
    tick();
    check("new_round_hi", 32'(bus.new_round), 32'd1);
    check("map_sel_kept", 32'(bus.map_sel), 32'd1);
    bus.keycode = '0;
    tick();
    check("new_round_lo", 32'(bus.new_round), 32'd0);
    check("play_screen", 32'(bus.screen), 32'd3);
    check("play_en", 32'(bus.play_en), 32'd1);

    // Player 1 wins a round.
    round_end(2'd1, 1'b0);
    check("score_p1_1", 32'(bus.scores), 32'h04);
    tick();
    check("round_end_screen", 32'(bus.screen), 32'd5);
    press_key(8'd88, 0);
    check("replay_screen", 32'(bus.screen), 32'd3);

    // Pause; round_over while paused is ignored; unpause without new_round.
    press_key(8'd41, 0);
    check("paused_screen", 32'(bus.screen), 32'd4);
    check("paused_en", 32'({bus.play_en, bus.pause_en}), 32'b01);
    round_end(2'd1, 1'b0);
    tick();
    check("paused_ignore_ro", 32'(bus.scores), 32'h04);
    check("paused_still", 32'(bus.screen), 32'd4);
    bus.keycode = {8'd0, 8'd41};
    tick();
    check("unpause_no_nr", 32'(bus.new_round), 32'd0);
    bus.keycode = '0;
    tick();
    check("unpause_screen", 32'(bus.screen), 32'd3);
    check("unpause_scores", 32'(bus.scores), 32'h04);

    // round_over coincides with PAUSE press: round_over wins (player 0).
    bus.keycode = {8'd0, 8'd41};
    round_end(2'd0, 1'b0);
    bus.keycode = '0;
    tick();
    check("ro_beats_pause", 32'(bus.screen), 32'd5);
    check("score_p0_1", 32'(bus.scores), 32'h05);

    // Tie, then out-of-range winner: both end the round without scoring.
    press_key(8'd88, 0);
    round_end(2'd2, 1'b1);
    tick();
    check("tie_screen", 32'(bus.screen), 32'd5);
    check("tie_scores", 32'(bus.scores), 32'h05);
    press_key(8'd88, 0);
    round_end(2'd3, 1'b0);
    tick();
    check("oor_screen", 32'(bus.screen), 32'd5);
    check("oor_scores", 32'(bus.scores), 32'h05);

    // Player 1 reaches ROUNDS_TO_WIN=2: match over.
    press_key(8'd88, 0);
    round_end(2'd1, 1'b0);
    check("match_winner", 32'(bus.match_winner), 32'd1);
    check("final_scores", 32'(bus.scores), 32'h09);
    tick();
    check("match_end_screen", 32'(bus.screen), 32'd6);

    // MATCH_END -> MENU keeps scores; MAP_SELECT entry clears them.
    press_key(8'd88, 0);
    check("menu_again", 32'(bus.screen), 32'd1);
    check("menu_scores_held", 32'(bus.scores), 32'h09);
    check("menu_winner_held", 32'(bus.match_winner), 32'd1);
    press_key(8'd88, 0);
    check("ms_scores_clr", 32'(bus.scores), 32'd0);
    check("ms_winner_clr", 32'(bus.match_winner), 32'd0);
    check("ms_screen", 32'(bus.screen), 32'd2);

    // Mid-play asynchronous reset.
    press_key(8'd88, 0);
    round_end(2'd2, 1'b0);
    check("score_p2_1", 32'(bus.scores), 32'h10);
    Reset_n = 1'b0;
    #1;
    check("async_rst_screen", 32'(bus.screen), 32'd0);
    check("async_rst_scores", 32'(bus.scores), 32'd0);
    check("async_rst_map", 32'(bus.map_sel), 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    tick();
    check("post_rst_menu", 32'(bus.screen), 32'd1);

`ifdef ROUND_TIMER_EN
    // 40 PLAY cycles, 50 PAUSED, 60 PLAY -> expiry on PLAY cycle 100.
    press_key(8'd88, 0);
    press_key(8'd88, 0);
    repeat (38) tick();
    bus.keycode = {8'd0, 8'd41};
    tick();
    bus.keycode = '0;
    repeat (49) tick();
    check("tmr_paused", 32'(bus.screen), 32'd4);
    bus.keycode = {8'd0, 8'd41};
    tick();
    bus.keycode = '0;
    repeat (59) tick();
    check("tmr_not_yet", 32'(bus.timer_expired), 32'd0);
    check("tmr_still_play", 32'(bus.screen), 32'd3);
    tick();
    check("tmr_expired", 32'(bus.timer_expired), 32'd1);
    tick();
    check("tmr_pulse_end", 32'(bus.timer_expired), 32'd0);
    check("tmr_round_end", 32'(bus.screen), 32'd5);
    check("tmr_scores", 32'(bus.scores), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
